// File: rtl/ll_pkg.sv
// Shared types and constants for the linked-list op sequencer.
// Contents: opcode and FSM state enums, default pool geometry, pointer type
// for the default geometry, and a NULL-pointer helper usable at any width.
package ll_pkg;

    // Opcode encoding as presented on op_code.
    typedef enum logic [1:0] {
        OP_PUSH  = 2'b00,
        OP_POP   = 2'b01,
        OP_PEEK  = 2'b10,
        OP_CLEAR = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_WALK = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam int unsigned LL_DATA_W = 8;
    localparam int unsigned LL_DEPTH  = 8;
    localparam int unsigned LL_PTR_W  = $clog2(LL_DEPTH);

    // Node pointer: PTR_W index bits plus a NULL flag in the MSB.
    typedef logic [LL_PTR_W:0] ptr_t;

    localparam ptr_t PTR_NULL = ptr_t'(1 << LL_PTR_W);

    // NULL pointer for an arbitrary index width: only the flag bit set.
    function automatic logic [31:0] null_ptr(input int unsigned ptr_w);
        return 32'(1) << ptr_w;
    endfunction

endpackage

// File: rtl/ll_op_sequencer_if.sv
// Command/response bundle between the pulse-generator stage and the
// linked-list op sequencer.
//   master: drives op_start/op_code/op_data/op_index, observes status
//   slave : the sequencer; drives busy/done/err/rd_data/count/empty/full
interface ll_op_sequencer_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PTR_W  = 3
);
    logic              op_start;
    logic [1:0]        op_code;
    logic [DATA_W-1:0] op_data;
    logic [PTR_W-1:0]  op_index;

    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rd_data;
    logic [PTR_W:0]    count;
    logic              empty;
    logic              full;

    modport master (
        output op_start, op_code, op_data, op_index,
        input  busy, done, err, rd_data, count, empty, full
    );

    modport slave (
        input  op_start, op_code, op_data, op_index,
        output busy, done, err, rd_data, count, empty, full
    );
endinterface

// File: rtl/ll_node_pool.sv
// Register-based node pool: payload array and next-pointer array.
// Ports:
//   clk                         clock
//   init                        bulk re-init of next pointers into one free chain
//   data_we/data_waddr/data_wdata  payload write port
//   next_we/next_waddr/next_wdata  next-pointer write port
//   ra_addr -> ra_data, ra_next    async read port A (payload + next)
//   rb_addr -> rb_next             async read port B (next only)
module ll_node_pool
    import ll_pkg::*;
#(
    parameter int unsigned DATA_W = LL_DATA_W,
    parameter int unsigned DEPTH  = LL_DEPTH,
    parameter int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              init,
    input  logic              data_we,
    input  logic [PTR_W-1:0]  data_waddr,
    input  logic [DATA_W-1:0] data_wdata,
    input  logic              next_we,
    input  logic [PTR_W-1:0]  next_waddr,
    input  logic [PTR_W:0]    next_wdata,
    input  logic [PTR_W-1:0]  ra_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [PTR_W:0]    ra_next,
    input  logic [PTR_W-1:0]  rb_addr,
    output logic [PTR_W:0]    rb_next
);
    localparam int unsigned NP_W = PTR_W + 1;
    localparam logic [NP_W-1:0] NULL_P = NP_W'(null_ptr(PTR_W));

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [NP_W-1:0]   next_mem [DEPTH];

    // Payload storage carries no reset; only live nodes are ever read.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_mem[data_waddr] <= data_wdata;
        end
    end

    // Init threads every node into the free chain 0 -> 1 -> ... -> NULL.
    always_ff @(posedge clk) begin
        if (init) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                next_mem[PTR_W'(i)] <= (i == DEPTH - 1) ? NULL_P : NP_W'(i + 1);
            end
        end else if (next_we) begin
            next_mem[next_waddr] <= next_wdata;
        end
    end

    assign ra_data = data_mem[ra_addr];
    assign ra_next = next_mem[ra_addr];
    assign rb_next = next_mem[rb_addr];

endmodule

// File: rtl/ll_op_sequencer.sv
// Single-command linked-list engine: one PUSH/POP/PEEK/CLEAR per op_start
// pulse, on a register-based node pool, finishing with a one-cycle done.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset (also re-initialises the pool)
//   bus    slave side of ll_op_sequencer_if (command in, status/result out)
module ll_op_sequencer
    import ll_pkg::*;
#(
    parameter int unsigned DATA_W = LL_DATA_W,
    parameter int unsigned DEPTH  = LL_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    ll_op_sequencer_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned NP_W  = PTR_W + 1;
    localparam logic [NP_W-1:0] NULL_P = NP_W'(null_ptr(PTR_W));

    state_t            state;
    op_t               op_q;
    logic [DATA_W-1:0] data_q;
    logic [PTR_W-1:0]  index_q;
    logic [NP_W-1:0]   head;
    logic [NP_W-1:0]   free_head;
    logic [NP_W-1:0]   count_q;
    logic [PTR_W-1:0]  cur;
    logic [PTR_W-1:0]  rem;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              empty_q;
    logic              full_q;

    logic              op_err;
    logic              pool_init;
    logic              data_we;
    logic              next_we;
    logic [PTR_W-1:0]  next_waddr;
    logic [NP_W-1:0]   next_wdata;
    logic [PTR_W-1:0]  ra_addr;
    logic [DATA_W-1:0] pa_data;
    logic [NP_W-1:0]   pa_next;
    logic [NP_W-1:0]   pb_next;

    ll_node_pool #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_pool (
        .clk        (clk),
        .init       (pool_init),
        .data_we    (data_we),
        .data_waddr (free_head[PTR_W-1:0]),
        .data_wdata (data_q),
        .next_we    (next_we),
        .next_waddr (next_waddr),
        .next_wdata (next_wdata),
        .ra_addr    (ra_addr),
        .ra_data    (pa_data),
        .ra_next    (pa_next),
        .rb_addr    (free_head[PTR_W-1:0]),
        .rb_next    (pb_next)
    );

    // Rejection check for the latched op, evaluated against current status.
    always_comb begin
        op_err = 1'b0;
        case (op_q)
            OP_PUSH: op_err = full_q;
            OP_POP:  op_err = empty_q;
            OP_PEEK: op_err = ({1'b0, index_q} >= count_q);
            default: op_err = 1'b0;
        endcase
    end

    // Pool write strobes; only a successful EXEC touches the pool.
    always_comb begin
        pool_init  = reset;
        data_we    = 1'b0;
        next_we    = 1'b0;
        next_waddr = free_head[PTR_W-1:0];
        next_wdata = head;
        ra_addr    = (state == S_WALK) ? cur : head[PTR_W-1:0];
        if (state == S_EXEC && !op_err) begin
            case (op_q)
                OP_PUSH: begin
                    data_we = 1'b1;
                    next_we = 1'b1;
                end
                OP_POP: begin
                    // Popped node rejoins the front of the free chain.
                    next_we    = 1'b1;
                    next_waddr = head[PTR_W-1:0];
                    next_wdata = free_head;
                end
                OP_CLEAR: pool_init = 1'b1;
                default: ;
            endcase
        end
    end

    // Sequencer FSM, list registers and all registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            op_q      <= OP_PUSH;
            data_q    <= '0;
            index_q   <= '0;
            head      <= NULL_P;
            free_head <= '0;
            count_q   <= '0;
            cur       <= '0;
            rem       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.op_start) begin
                        op_q    <= op_t'(bus.op_code);
                        data_q  <= bus.op_data;
                        index_q <= bus.op_index;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_err || op_q != OP_PEEK) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end
                    if (op_err) begin
                        err_q <= 1'b1;
                    end else begin
                        case (op_q)
                            OP_PUSH: begin
                                head      <= free_head;
                                free_head <= pb_next;
                                count_q   <= count_q + NP_W'(1);
                                empty_q   <= 1'b0;
                                full_q    <= (count_q == NP_W'(DEPTH - 1));
                            end
                            OP_POP: begin
                                rd_data_q <= pa_data;
                                head      <= pa_next;
                                free_head <= head;
                                count_q   <= count_q - NP_W'(1);
                                empty_q   <= (count_q == NP_W'(1));
                                full_q    <= 1'b0;
                            end
                            OP_PEEK: begin
                                cur   <= head[PTR_W-1:0];
                                rem   <= index_q;
                                state <= S_WALK;
                            end
                            OP_CLEAR: begin
                                head      <= NULL_P;
                                free_head <= '0;
                                count_q   <= '0;
                                rd_data_q <= '0;
                                empty_q   <= 1'b1;
                                full_q    <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_WALK: begin
                    // One hop per cycle; index was bounds-checked in EXEC.
                    if (rem == '0) begin
                        rd_data_q <= pa_data;
                        done_q    <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cur <= pa_next[PTR_W-1:0];
                        rem <= rem - PTR_W'(1);
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
    assign bus.rd_data = rd_data_q;
    assign bus.count   = count_q;
    assign bus.empty   = empty_q;
    assign bus.full    = full_q;

endmodule

// File: tb/tb_ll_op_sequencer.sv
// Scoreboard bench for ll_op_sequencer: the driver queues hand-computed
// completions, an independent monitor checks each done pulse against them.
module tb_ll_op_sequencer;
    import ll_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    typedef struct {
        string      name;
        bit         err;
        logic [7:0] rd;
        int         lat;
        int         cnt;
        int         start;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    ll_op_sequencer_if #(.DATA_W(8), .PTR_W(3)) bus ();

    ll_op_sequencer #(.DATA_W(8), .DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, ".err"},     32'(bus.err),     32'(mon_e.err));
                check({mon_e.name, ".rd_data"}, 32'(bus.rd_data), 32'(mon_e.rd));
                check({mon_e.name, ".latency"}, 32'(cyc - mon_e.start), 32'(mon_e.lat));
                check({mon_e.name, ".count"},   32'(bus.count),   32'(mon_e.cnt));
            end
        end
    end

    task automatic push_exp(input string nm, input bit e, input logic [7:0] rd,
                            input int lat, input int cnt);
        exp_t x;
        x.name = nm; x.err = e; x.rd = rd; x.lat = lat; x.cnt = cnt; x.start = cyc;
        exp_q.push_back(x);
    endtask

    // Drive a one-cycle op_start from a negedge; returns at the next negedge.
    task automatic start_op(input logic [1:0] code, input logic [7:0] d, input logic [2:0] idx);
        bus.op_start = 1'b1;
        bus.op_code  = code;
        bus.op_data  = d;
        bus.op_index = idx;
        @(negedge clk);
        bus.op_start = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s.timeout: got %0d pending completions, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_op(input string nm, input logic [1:0] code, input logic [7:0] d,
                         input logic [2:0] idx, input bit e, input logic [7:0] rd,
                         input int lat, input int cnt);
        push_exp(nm, e, rd, lat, cnt);
        start_op(code, d, idx);
        wait_drain(nm);
    endtask

    logic [7:0] peek_exp [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        bus.op_start = 1'b0;
        bus.op_code  = 2'b00;
        bus.op_data  = 8'h00;
        bus.op_index = 3'd0;
        repeat (2) @(negedge clk);
        check("rst.busy",  32'(bus.busy),    0);
        check("rst.done",  32'(bus.done),    0);
        check("rst.err",   32'(bus.err),     0);
        check("rst.rd",    32'(bus.rd_data), 0);
        check("rst.count", 32'(bus.count),   0);
        check("rst.empty", 32'(bus.empty),   1);
        check("rst.full",  32'(bus.full),    0);
        reset = 1'b0;
        @(negedge clk);

        // Basic pushes and indexed peeks.
        do_op("push11", OP_PUSH, 8'h11, 3'd0, 0, 8'h00, 2, 1);
        do_op("push22", OP_PUSH, 8'h22, 3'd0, 0, 8'h00, 2, 2);
        do_op("push33", OP_PUSH, 8'h33, 3'd0, 0, 8'h00, 2, 3);
        check("after3.empty", 32'(bus.empty), 0);
        do_op("peek0", OP_PEEK, 8'h00, 3'd0, 0, 8'h33, 3, 3);
        do_op("peek1", OP_PEEK, 8'h00, 3'd1, 0, 8'h22, 4, 3);
        do_op("peek2", OP_PEEK, 8'h00, 3'd2, 0, 8'h11, 5, 3);
        do_op("peek3_oob", OP_PEEK, 8'h00, 3'd3, 1, 8'h11, 2, 3);

        // Pops down to empty, then underflow.
        do_op("pop33", OP_POP, 8'h00, 3'd0, 0, 8'h33, 2, 2);
        do_op("pop22", OP_POP, 8'h00, 3'd0, 0, 8'h22, 2, 1);
        do_op("pop11", OP_POP, 8'h00, 3'd0, 0, 8'h11, 2, 0);
        do_op("pop_empty", OP_POP, 8'h00, 3'd0, 1, 8'h11, 2, 0);
        check("drained.empty", 32'(bus.empty), 1);

        // Fill to capacity, overflow, then recycle freed nodes.
        for (int i = 1; i <= 8; i++)
            do_op("fill", OP_PUSH, 8'(i), 3'd0, 0, 8'h11, 2, i);
        check("fill.full", 32'(bus.full), 1);
        do_op("push_full", OP_PUSH, 8'h09, 3'd0, 1, 8'h11, 2, 8);
        do_op("pop08", OP_POP, 8'h00, 3'd0, 0, 8'h08, 2, 7);
        check("pop08.full", 32'(bus.full), 0);
        do_op("pop07", OP_POP, 8'h00, 3'd0, 0, 8'h07, 2, 6);
        do_op("pushAA", OP_PUSH, 8'hAA, 3'd0, 0, 8'h07, 2, 7);
        do_op("pushBB", OP_PUSH, 8'hBB, 3'd0, 0, 8'h07, 2, 8);
        check("refill.full", 32'(bus.full), 1);
        peek_exp = '{8'hBB, 8'hAA, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        for (int i = 0; i < 8; i++)
            do_op("lifo_peek", OP_PEEK, 8'h00, 3'(i), 0, peek_exp[i], 3 + i, 8);

        // op_start while busy and coincident with done must be dropped.
        push_exp("peek7_ign", 0, 8'h01, 10, 8);
        start_op(OP_PEEK, 8'h00, 3'd7);
        start_op(OP_CLEAR, 8'h00, 3'd0);
        for (int i = 0; i < 40 && !bus.done; i++) @(negedge clk);
        if (!bus.done) begin
            tests++;
            fails++;
            $display("FAIL peek7_ign.done_wait: got done=0, required done within bound");
        end
        start_op(OP_CLEAR, 8'h00, 3'd0);
        check("ign.busy",  32'(bus.busy),    0);
        check("ign.count", 32'(bus.count),   8);
        check("ign.rd",    32'(bus.rd_data), 32'h01);
        wait_drain("peek7_ign");

        // Reset during WALK aborts without a done pulse.
        start_op(OP_PEEK, 8'h00, 3'd5);
        @(negedge clk);
        @(negedge clk);
        check("walk.busy", 32'(bus.busy), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst.busy",  32'(bus.busy),  0);
        check("midrst.done",  32'(bus.done),  0);
        check("midrst.count", 32'(bus.count), 0);
        check("midrst.empty", 32'(bus.empty), 1);
        reset = 1'b0;
        @(negedge clk);

        // CLEAR of a 4-node list, then a full refill from the fresh pool.
        for (int i = 1; i <= 5; i++)
            do_op("pre_clr", OP_PUSH, 8'hC0 + 8'(i), 3'd0, 0, 8'h00, 2, i);
        do_op("popC5", OP_POP, 8'h00, 3'd0, 0, 8'hC5, 2, 4);
        do_op("clear", OP_CLEAR, 8'h00, 3'd0, 0, 8'h00, 2, 0);
        check("clear.empty", 32'(bus.empty), 1);
        for (int i = 0; i < 8; i++)
            do_op("post_clr", OP_PUSH, 8'hD0 + 8'(i), 3'd0, 0, 8'h00, 2, i + 1);
        check("post_clr.full", 32'(bus.full), 1);
        do_op("peek7_D0", OP_PEEK, 8'h00, 3'd7, 0, 8'hD0, 10, 8);
        do_op("peek0_D7", OP_PEEK, 8'h00, 3'd0, 0, 8'hD7, 3, 8);

        repeat (5) @(negedge clk);
        check("final.pending", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
